// File: rtl/eth_phy_10g_tx_framer.sv
// 10GBASE-R TX 64b/66b block framer: idle insertion, header check, x^58+x^39+1 scrambling.
// Optional PRBS31 test-pattern source is enabled by defining TX_FRAMER_PRBS31_EN.
module eth_phy_10g_tx_framer #(
  parameter int DATA_WIDTH       = 64,
  parameter int HDR_WIDTH        = 2,
  parameter int INIT_IDLES       = 16,
  parameter bit SCRAMBLER_BYPASS = 1'b0
) (
  input  logic                  clk_tb,
  input  logic                  rx_rst_tb,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic [HDR_WIDTH-1:0]  i_tx_hdr,
  input  logic                  i_tx_valid,
  output logic                  o_tx_ready,
  input  logic                  i_serdes_tx_pause,
`ifdef TX_FRAMER_PRBS31_EN
  input  logic                  i_prbs31_enable,
`endif
  output logic [DATA_WIDTH-1:0] o_serdes_tx_data,
  output logic [HDR_WIDTH-1:0]  o_serdes_tx_hdr,
  output logic [15:0]           o_idle_count,
  output logic [15:0]           o_err_count
);

  // state   | meaning
  // ST_INIT | emitting the post-reset idle preamble, payload not accepted
  // ST_RUN  | one block per non-paused cycle: payload on transfer, else idle
  typedef enum logic [0:0] {ST_INIT, ST_RUN} state_t;

  localparam logic [63:0] IDLE_DATA = 64'h000000000000001E;
  localparam logic [63:0] ERR_DATA  = 64'h3C78F1E3C78F1E1E;
  localparam logic [1:0]  HDR_DATA  = 2'b01;
  localparam logic [1:0]  HDR_CTRL  = 2'b10;
  localparam logic [15:0] INIT_LAST = 16'(INIT_IDLES - 1);

  state_t                  r_state;
  logic [15:0]             r_init_cnt;
  logic [57:0]             r_scr;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [HDR_WIDTH-1:0]    r_hdr;
  logic [15:0]             r_idle_cnt;
  logic [15:0]             r_err_cnt;

  logic                    w_xfer;
  logic                    w_hdr_bad;
  logic [1:0]              w_blk_hdr;
  logic [63:0]             w_blk_data;
  logic [63:0]             w_scr_data;
  logic [57:0]             w_scr_next;

  // Bit-serial scrambler unrolled across the block, LSB first.
  function automatic logic [121:0] scramble(input logic [63:0] d, input logic [57:0] s);
    logic [57:0] st;
    logic [63:0] o;
    st = s;
    o  = '0;
    for (int i = 0; i < 64; i++) begin
      o[i] = d[i] ^ st[38] ^ st[57];
      st   = {st[56:0], o[i]};
    end
    return {st, o};
  endfunction

`ifdef TX_FRAMER_PRBS31_EN
  logic [30:0] r_prbs;
  logic [30:0] w_prbs_next;
  logic [63:0] w_prbs_data;
  logic        w_prbs_active;

  function automatic logic [94:0] prbs64(input logic [30:0] p);
    logic [30:0] st;
    logic [63:0] o;
    logic        b;
    st = p;
    o  = '0;
    for (int i = 0; i < 64; i++) begin
      b    = st[30] ^ st[27];
      o[i] = b;
      st   = {st[29:0], b};
    end
    return {st, o};
  endfunction

  assign w_prbs_active              = (r_state == ST_RUN) & i_prbs31_enable;
  assign {w_prbs_next, w_prbs_data} = prbs64(r_prbs);
  assign o_tx_ready = (r_state == ST_RUN) & ~i_serdes_tx_pause & ~i_prbs31_enable;
`else
  assign o_tx_ready = (r_state == ST_RUN) & ~i_serdes_tx_pause;
`endif

  assign w_xfer    = i_tx_valid & o_tx_ready;
  assign w_hdr_bad = (i_tx_hdr != HDR_DATA) && (i_tx_hdr != HDR_CTRL);

  always_comb begin
    w_blk_hdr  = HDR_CTRL;
    w_blk_data = IDLE_DATA;
    if (w_xfer) begin
      if (w_hdr_bad) begin
        w_blk_data = ERR_DATA;
      end else begin
        w_blk_hdr  = i_tx_hdr;
        w_blk_data = i_tx_data;
      end
    end
  end

  assign {w_scr_next, w_scr_data} = scramble(w_blk_data, r_scr);

  always_ff @(posedge clk_tb or posedge rx_rst_tb) begin
    if (rx_rst_tb) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
      r_scr      <= '1;
      r_data     <= '0;
      r_hdr      <= '0;
      r_idle_cnt <= '0;
      r_err_cnt  <= '0;
`ifdef TX_FRAMER_PRBS31_EN
      r_prbs     <= '1;
`endif
    end else if (!i_serdes_tx_pause) begin
`ifdef TX_FRAMER_PRBS31_EN
      if (w_prbs_active) begin
        r_hdr  <= HDR_DATA;
        r_data <= w_prbs_data;
        r_prbs <= w_prbs_next;
      end else begin
`else
      begin
`endif
        r_hdr  <= w_blk_hdr;
        r_data <= SCRAMBLER_BYPASS ? w_blk_data : w_scr_data;
        r_scr  <= w_scr_next;
        case (r_state)
          ST_INIT: begin
            r_init_cnt <= r_init_cnt + 16'd1;
            if (r_init_cnt == INIT_LAST) r_state <= ST_RUN;
          end
          ST_RUN: begin
            if (!w_xfer && r_idle_cnt != 16'hFFFF) r_idle_cnt <= r_idle_cnt + 16'd1;
            if (w_xfer && w_hdr_bad && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
          end
          default: r_state <= ST_INIT;
        endcase
      end
    end
  end

  assign o_serdes_tx_data = r_data;
  assign o_serdes_tx_hdr  = r_hdr;
  assign o_idle_count     = r_idle_cnt;
  assign o_err_count      = r_err_cnt;

endmodule

// File: doc/eth_phy_10g_tx_framer.md
Name: eth_phy_10g_tx_framer

Overview:
TX-side 64b/66b block framer for the 10GBASE-R PHY, the counterpart of the RX block aligner. It accepts 64-bit payloads with 2-bit sync headers through a valid/ready handshake and inserts idle blocks when no payload is offered. It replaces illegal headers with error blocks, scrambles the payload with the self-synchronous x^58+x^39+1 scrambler, and presents hdr/data to the SERDES gearbox. It honours the gearbox pause and emits a fixed idle preamble after reset so the far-end aligner can acquire block lock.

Parameters:
DATA_WIDTH, 64, payload width; only 64 is supported.
HDR_WIDTH, 2, sync header width; only 2 is supported.
INIT_IDLES, 16, number of idle blocks emitted after reset before data is accepted (1..65535).
SCRAMBLER_BYPASS, 0, 1 = data passes unscrambled (bench/debug only).

Ports:
clk_tb  in  1  clock.
rx_rst_tb  in  1  reset, asynchronous, active-high.
i_tx_data  in  64  payload, block-type byte in [7:0], LSB transmitted first.
i_tx_hdr  in  2  sync header: 2'b01 = data, 2'b10 = control.
i_tx_valid  in  1  payload offered.
o_tx_ready  out  1  framer will consume the payload this cycle.
i_serdes_tx_pause  in  1  gearbox pause; no block is emitted this cycle.
o_serdes_tx_data  out  64  scrambled payload.
o_serdes_tx_hdr  out  2  sync header, never scrambled.
o_idle_count  out  16  saturating count of inserted idle blocks.
o_err_count  out  16  saturating count of error-block substitutions.

Behaviour:
- Clock is clk_tb. Reset is rx_rst_tb, asynchronous, active-high. All state is cleared asynchronously.
- Reset values: o_serdes_tx_data = 0, o_serdes_tx_hdr = 2'b00, counters = 0, scrambler state = all ones (58'h3FFFFFFFFFFFFFF), FSM = INIT, init counter = 0.
- o_tx_ready = (state == RUN) & ~i_serdes_tx_pause. This is combinational from registered state and the pause input.
- A transfer occurs when i_tx_valid & o_tx_ready.
- FSM INIT:
  - Each non-paused cycle emits one idle block and increments the init counter.
  - When the counter reaches INIT_IDLES-1 on a non-paused cycle, go to RUN.
  - Preamble idles are not counted in o_idle_count.
- FSM RUN:
  - Each non-paused cycle emits exactly one block.
  - On a transfer, the block is the input payload.
  - Without a transfer, the block is an idle and o_idle_count increments.
- Idle block: hdr 2'b10, pre-scramble data 64'h000000000000001E.
- Header check: a transferred hdr of 2'b00 or 2'b11 is replaced by an error block (hdr 2'b10, data 64'h3C78F1E3C78F1E1E) and o_err_count increments. The payload is still consumed.
- Scrambler: LSB first, out[i] = in[i] ^ s[38] ^ s[57]. The state shifts in the scrambled bits. All 64 bits are processed in one cycle.
- Scrambler and header bypass:
  - SCRAMBLER_BYPASS=1 sends data unscrambled, but the state still advances.
  - The header is never scrambled.
- Latency: 1 cycle from transfer (or idle decision) to the output registers.
- Pause cycle: outputs hold their previous values, the scrambler and FSM hold, there is no transfer, and counters do not change.
- Both counters saturate at 16'hFFFF.
- Reset mid-operation returns to INIT. Any in-flight payload is dropped with no output glitch beyond the async clear.
- i_tx_valid while in INIT or paused: not consumed, no error. The upstream source must hold the payload until a transfer.

Optional Feature:
Macro TX_FRAMER_PRBS31_EN.
- Defined:
  - Adds input port i_prbs31_enable (1 bit) and a PRBS31 generator (x^31+x^28+1, seed all ones, 64 bits per non-paused cycle).
  - While the enable is high and state == RUN, o_serdes_tx_hdr = 2'b01 and o_serdes_tx_data = PRBS output. The scrambler is bypassed and holds.
  - In this mode o_tx_ready = 0 and neither counter changes.
  - Deasserting the enable resumes normal framing on the next non-paused cycle.
- Undefined: the port and generator are absent, and behaviour is exactly as above.

Test Plan:
1. Preamble: SCRAMBLER_BYPASS=1, INIT_IDLES=16, reset released, valid=0 -> 16 idle blocks (hdr 2'b10, data 64'h1E) with o_tx_ready = 0 throughout, then ready = 1, o_idle_count increments from cycle 17 and reads 4 after 4 more cycles.
2. Data path: bypass, RUN, send hdr 2'b01 / 64'hFFFFFFFF7FFFFFFF -> the same value appears on the outputs one cycle later; o_err_count stays 0.
3. Bad header: send hdr 2'b11 / 64'h0000000000000002, then hdr 2'b00 -> two error blocks (hdr 2'b10, 64'h3C78F1E3C78F1E1E); o_err_count = 2.
4. Pause: pulse i_serdes_tx_pause for 1 cycle in every 33 while streaming an incrementing payload -> ready is low on pause cycles, outputs hold, no payload is lost or duplicated, and the idle count is unchanged.
5. Scrambled loopback: SCRAMBLER_BYPASS=0, output looped into the team's RX aligner and a reference descrambler -> block lock asserts and the descrambled data equals the input payload sequence.
6. Reset mid-stream: assert rx_rst_tb for 3 cycles during streaming -> outputs read 0 immediately, counters read 0, then INIT_IDLES idles are emitted before ready returns high.
